iob_spi_slave_fl: RTL

IOB_SPI_SLAVE_FL -- requirements
Module: iob_spi_slave_fl

---
 rtl/iob_spi_slave_fl.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/iob_spi_slave_fl.sv
// SPI flash-emulating slave (mode 0) bridging a serial master onto a simple
// byte-wide memory request/ready backend.
//   clk, rst       : system clock, asynchronous active-low reset
//   sclk, ss, mosi : SPI master inputs (asynchronous, synchronized here)
//   miso           : SPI data to master, updated on SCLK falling edges
//   mem_valid/mem_addr/mem_wdata/mem_wr : backend request, held until mem_ready
//   mem_rdata/mem_ready                 : backend completion (one-clk strobe)
// Commands: 0x03 read, 0x0B fast read, 0x02 page write, 0x9F JEDEC ID,
// 0x05 read status, 0x06 write enable, 0x04 write disable.
module iob_spi_slave_fl #(
  parameter int          ADDR_W     = 24,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
  parameter int          DUMMY_FAST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_wr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_FAST  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDID  = 8'h9F;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_WRDI  = 8'h04;

  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_W - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_FAST - 1);
  localparam logic       HAS_DUMMY  = (DUMMY_FAST != 0);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, ID, STATUS, IGNORE
  } state_t;

  state_t            state, state_n;
  logic [1:0]        sclk_s, ss_s, mosi_s;
  logic              sclk_d;
  logic [1:0]        fill;
  logic              armed;
  logic [23:0]       sr;
  logic [7:0]        cnt;
  logic [7:0]        cmd;
  logic [ADDR_W-1:0] addr_cnt;
  logic              wel;
  logic              wr_stored;

  logic              sclk_rise, sclk_fall, ss_hi, mosi_b, wip;
  logic [7:0]        shift_in, status_byte;
  logic [ADDR_W-1:0] addr_in;

  always_comb begin
    sclk_rise   = sclk_s[1] & ~sclk_d;
    sclk_fall   = ~sclk_s[1] & sclk_d;
    ss_hi       = ss_s[1];
    mosi_b      = mosi_s[1];
    wip         = mem_valid & mem_wr;
    shift_in    = {sr[6:0], mosi_b};
    addr_in     = {addr_cnt[ADDR_W-2:0], mosi_b};
    status_byte = {6'b0, wel, wip};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // A negated ss aborts every state, but an outstanding backend request is
  // allowed to complete before the FSM drops back to IDLE.
  always_comb begin
    state_n = state;
    if (state != IDLE && ss_hi) begin
      if (!mem_valid) state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (armed && !ss_hi) state_n = CMD;
        CMD: begin
          if (sclk_rise && cnt == 8'd7) begin
            case (shift_in)
              CMD_READ, CMD_FAST, CMD_WRITE: state_n = ADDR;
              CMD_RDID:                      state_n = ID;
              CMD_RDSR:                      state_n = STATUS;
              default:                       state_n = IGNORE;
            endcase
          end
        end
        ADDR: begin
          if (sclk_rise && cnt == ADDR_LAST) begin
            if (cmd == CMD_FAST && HAS_DUMMY) state_n = DUMMY;
            else if (cmd == CMD_WRITE)        state_n = wel ? WR_DATA : IGNORE;
            else                              state_n = RD_DATA;
          end
        end
        DUMMY: if (sclk_rise && cnt == DUMMY_LAST) state_n = RD_DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s    <= '0;
      ss_s      <= '1;
      mosi_s    <= '0;
      sclk_d    <= 1'b0;
      fill      <= '0;
      armed     <= 1'b0;
      sr        <= '0;
      cnt       <= '0;
      cmd       <= '0;
      addr_cnt  <= '0;
      wel       <= 1'b0;
      wr_stored <= 1'b0;
      miso      <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], sclk};
      ss_s   <= {ss_s[0], ss};
      mosi_s <= {mosi_s[0], mosi};
      sclk_d <= sclk_s[1];
      fill   <= {fill[0], 1'b1};

      // Only arm once the synchronizer holds a real sample of a high ss, so
      // an ss already low when reset releases does not start a command.
      if (state == IDLE && state_n == CMD) armed <= 1'b0;
      else if (fill[1] && ss_hi)           armed <= 1'b1;

      if (mem_valid && mem_ready) begin
        mem_valid <= 1'b0;
        if (mem_wr) addr_cnt <= addr_cnt + ADDR_W'(1);
        else        sr       <= {mem_rdata, 16'h0};
      end

      if (ss_hi) begin
        miso <= 1'b0;
        cnt  <= '0;
        if (state != IDLE && state_n == IDLE && wr_stored) begin
          wel       <= 1'b0;
          wr_stored <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            miso <= 1'b0;
            if (state_n == CMD) begin
              cnt       <= '0;
              sr        <= '0;
              wr_stored <= 1'b0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              sr  <= {sr[22:0], mosi_b};
              cnt <= cnt + 8'd1;
              if (cnt == 8'd7) begin
                cmd <= shift_in;
                cnt <= '0;
                if (shift_in == CMD_WREN) wel <= 1'b1;
                if (shift_in == CMD_WRDI) wel <= 1'b0;
                if (shift_in == CMD_RDID) sr  <= JEDEC_ID;
              end
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              addr_cnt <= addr_in;
              cnt      <= cnt + 8'd1;
              if (cnt == ADDR_LAST) begin
                cnt <= '0;
                if (state_n == RD_DATA) begin
                  mem_valid <= 1'b1;
                  mem_wr    <= 1'b0;
                  mem_addr  <= addr_in;
                end
              end
            end
          end
          DUMMY: begin
            if (sclk_rise) begin
              cnt <= cnt + 8'd1;
              if (cnt == DUMMY_LAST) begin
                cnt       <= '0;
                mem_valid <= 1'b1;
                mem_wr    <= 1'b0;
                mem_addr  <= addr_cnt;
              end
            end
          end
          RD_DATA: begin
            if (sclk_fall) begin
              miso <= sr[23];
              sr   <= {sr[22:0], 1'b0};
              // Presenting bit 0: fetch the next byte so it is ready for
              // the following falling edge.
              if (cnt == 8'd7) begin
                cnt       <= '0;
                addr_cnt  <= addr_cnt + ADDR_W'(1);
                mem_valid <= 1'b1;
                mem_wr    <= 1'b0;
                mem_addr  <= addr_cnt + ADDR_W'(1);
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          WR_DATA: begin
            if (sclk_rise) begin
              sr <= {sr[22:0], mosi_b};
              if (cnt == 8'd7) begin
                cnt       <= '0;
                mem_valid <= 1'b1;
                mem_wr    <= 1'b1;
                mem_addr  <= addr_cnt;
                mem_wdata <= shift_in;
                wr_stored <= 1'b1;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          ID: begin
            if (sclk_fall) begin
              miso <= sr[23];
              sr   <= {sr[22:0], 1'b0};
            end
          end
          STATUS: begin
            if (sclk_fall) begin
              miso <= status_byte[~cnt[2:0]];
              cnt  <= (cnt == 8'd7) ? '0 : cnt + 8'd1;
            end
          end
          default: miso <= 1'b0;
        endcase
      end
    end
  end

endmodule
